// File: rtl/dc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dc_fifo
// Description : Single-clock FIFO of 2**AWIDTH words x DWIDTH bits. It exposes
//               both the write-side and read-side flag/usedw port sets, so it
//               can stand in for the dual-view FIFO wherever that is expected.
//               SHOWAHEAD="ON" gives first-word-fall-through; "OFF" gives a
//               registered q_o that updates one cycle after a read request.
//               Define DC_FIFO_CLEAR_MEM_EN to make srst_i clear the storage.
// Revision    : 1.0 - initial release
// ============================================================================
module dc_fifo #(
  parameter int    DWIDTH    = 8,
  parameter int    AWIDTH    = 3,
  parameter string SHOWAHEAD = "ON"
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_req_i,
  input  logic              rd_req_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              wr_empty_o,
  output logic              wr_full_o,
  output logic [AWIDTH-1:0] wr_usedw_o,
  output logic              rd_empty_o,
  output logic              rd_full_o,
  output logic [AWIDTH-1:0] rd_usedw_o
);

  localparam int                c_DEPTH    = 2 ** AWIDTH;
  localparam logic [AWIDTH:0]   c_CNT_FULL = (AWIDTH + 1)'(c_DEPTH);
  localparam logic [AWIDTH:0]   c_CNT_ONE  = (AWIDTH + 1)'(1);
  localparam logic [AWIDTH-1:0] c_PTR_ONE  = AWIDTH'(1);

  logic [DWIDTH-1:0] mem_q [c_DEPTH];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q,  count_d;

  logic w_empty;
  logic w_full;
  logic w_wr_valid;
  logic w_rd_valid;

  // Flags come straight from the registered count, so they already reflect
  // the most recent edge. Validity uses the pre-edge flags: a simultaneous
  // request on an empty FIFO only writes, on a full FIFO only reads.
  assign w_empty    = (count_q == '0);
  assign w_full     = (count_q == c_CNT_FULL);
  assign w_wr_valid = wr_req_i & ~w_full;
  assign w_rd_valid = rd_req_i & ~w_empty;

  // Both views are the same single-clock state.
  assign wr_empty_o = w_empty;
  assign wr_full_o  = w_full;
  assign wr_usedw_o = count_q[AWIDTH-1:0];
  assign rd_empty_o = w_empty;
  assign rd_full_o  = w_full;
  assign rd_usedw_o = count_q[AWIDTH-1:0];

  // Next pointers and count; a simultaneous valid read and write leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr_valid) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    if (w_rd_valid) rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    case ({w_wr_valid, w_rd_valid})
      2'b10:   count_d = count_q + c_CNT_ONE;
      2'b01:   count_d = count_q - c_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset discards contents even mid-operation.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef DC_FIFO_CLEAR_MEM_EN
  // Storage write port; reset also zeroes every word so the head reads 0.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_wr_valid) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end
`else
  // Storage write port; contents are undefined until written.
  always_ff @(posedge clk_i) begin
    if (!srst_i && w_wr_valid) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end
`endif

  generate
    if (SHOWAHEAD == "ON") begin : g_showahead
      // Head word is visible without a request; valid whenever not empty.
      assign q_o = mem_q[rd_ptr_q];
    end else begin : g_registered
      logic [DWIDTH-1:0] q_q;
      // Capture the popped head at each valid read; hold otherwise.
      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          q_q <= '0;
        end else if (w_rd_valid) begin
          q_q <= mem_q[rd_ptr_q];
        end
      end
      assign q_o = q_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_dc_fifo
// Description : Self-checking bench for dc_fifo. One instance in show-ahead
//               mode and one in registered mode share the same stimulus. A
//               vector table carries the expected flags; a queue of written
//               words supplies the expected read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dc_fifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst   = 1'b1;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic [DW-1:0] data   = '0;

  logic [DW-1:0] q_on,  q_off;
  logic          we_on, wf_on, re_on, rf_on;
  logic          we_off, wf_off, re_off, rf_off;
  logic [AW-1:0] wu_on, ru_on, wu_off, ru_off;

  dc_fifo #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD("ON")) u_on (
    .clk_i(clk), .srst_i(srst), .wr_req_i(wr_req), .rd_req_i(rd_req),
    .data_i(data), .q_o(q_on),
    .wr_empty_o(we_on), .wr_full_o(wf_on), .wr_usedw_o(wu_on),
    .rd_empty_o(re_on), .rd_full_o(rf_on), .rd_usedw_o(ru_on)
  );

  dc_fifo #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD("OFF")) u_off (
    .clk_i(clk), .srst_i(srst), .wr_req_i(wr_req), .rd_req_i(rd_req),
    .data_i(data), .q_o(q_off),
    .wr_empty_o(we_off), .wr_full_o(wf_off), .wr_usedw_o(wu_off),
    .rd_empty_o(re_off), .rd_full_o(rf_off), .rd_usedw_o(ru_off)
  );

  typedef struct {
    string         name;
    logic          srst;
    logic          wr;
    logic          rd;
    logic [DW-1:0] data;
    logic          e_empty;
    logic          e_full;
    logic [AW-1:0] e_usedw;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] model[$];      // scoreboard: words accepted, not yet popped
  logic [DW-1:0] exp_q_off = '0;
  int            total = 0;
  int            bad   = 0;
  int            step_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic s, input logic w, input logic r,
                     input logic [DW-1:0] d, input logic e, input logic f,
                     input logic [AW-1:0] u);
    vec_t v;
    v.name = name; v.srst = s; v.wr = w; v.rd = r; v.data = d;
    v.e_empty = e; v.e_full = f; v.e_usedw = u;
    vecs.push_back(v);
  endtask

  // Drive one cycle, advance the scoreboard, then check both instances.
  task automatic apply(input vec_t v);
    logic  wv, rv;
    string t;
    srst   = v.srst;
    wr_req = v.wr;
    rd_req = v.rd;
    data   = v.data;
    wv = v.wr && (model.size() < DEPTH);
    rv = v.rd && (model.size() > 0);
    @(posedge clk);
    #1;
    step_no++;
    t = $sformatf("%s#%0d", v.name, step_no);
    if (v.srst) begin
      model.delete();
      exp_q_off = '0;
    end else begin
      if (rv) exp_q_off = model.pop_front();
      if (wv) model.push_back(v.data);
    end
    chk({t, " wr_empty_on"},  we_on,  v.e_empty);
    chk({t, " rd_empty_on"},  re_on,  v.e_empty);
    chk({t, " wr_full_on"},   wf_on,  v.e_full);
    chk({t, " rd_full_on"},   rf_on,  v.e_full);
    chk({t, " wr_usedw_on"},  wu_on,  v.e_usedw);
    chk({t, " rd_usedw_on"},  ru_on,  v.e_usedw);
    chk({t, " wr_empty_off"}, we_off, v.e_empty);
    chk({t, " rd_empty_off"}, re_off, v.e_empty);
    chk({t, " wr_full_off"},  wf_off, v.e_full);
    chk({t, " rd_full_off"},  rf_off, v.e_full);
    chk({t, " wr_usedw_off"}, wu_off, v.e_usedw);
    chk({t, " rd_usedw_off"}, ru_off, v.e_usedw);
    chk({t, " q_off"}, q_off, exp_q_off);
    if (model.size() > 0) chk({t, " q_on_head"}, q_on, model[0]);
  endtask

  function automatic vec_t mk(input string name, input logic s, input logic w,
                              input logic r, input logic [DW-1:0] d, input logic e,
                              input logic f, input logic [AW-1:0] u);
    vec_t v;
    v.name = name; v.srst = s; v.wr = w; v.rd = r; v.data = d;
    v.e_empty = e; v.e_full = f; v.e_usedw = u;
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd();
    // Stay below 8'hAA so the overflow word can never be mistaken for fill data.
    return DW'($urandom_range(0, 8'hA9));
  endfunction

  initial begin
    // Reset, then fill to full.
    add("reset", 1, 0, 0, 8'h00, 1, 0, 3'd0);
    for (int k = 1; k <= 7; k++) add("fill", 0, 1, 0, rnd(), 0, 0, AW'(k));
    add("fill8", 0, 1, 0, rnd(), 0, 1, 3'd0);
    // Write while full is ignored.
    add("overflow", 0, 1, 0, 8'hAA, 0, 1, 3'd0);
    // Drain eight words; empty only after the eighth pop.
    for (int k = 1; k <= 7; k++) add("drain", 0, 0, 1, 8'h00, 0, 0, AW'(8 - k));
    add("drain8", 0, 0, 1, 8'h00, 1, 0, 3'd0);
    add("rd_empty", 0, 0, 1, 8'h00, 1, 0, 3'd0);
    // Build count=3, then simultaneous read/write holds it.
    for (int k = 1; k <= 3; k++) add("pre3", 0, 1, 0, rnd(), 0, 0, AW'(k));
    for (int k = 0; k < 4; k++)  add("simul", 0, 1, 1, rnd(), 0, 0, 3'd3);
    add("post", 0, 0, 1, 8'h00, 0, 0, 3'd2);
    add("post", 0, 0, 1, 8'h00, 0, 0, 3'd1);
    add("post", 0, 0, 1, 8'h00, 1, 0, 3'd0);
    // Both requests on empty: only the write takes effect.
    add("simul_empty", 0, 1, 1, rnd(), 0, 0, 3'd1);
    for (int k = 2; k <= 7; k++) add("refill", 0, 1, 0, rnd(), 0, 0, AW'(k));
    add("refill8", 0, 1, 0, rnd(), 0, 1, 3'd0);
    // Both requests on full: only the read takes effect.
    add("simul_full", 0, 1, 1, 8'hAA, 0, 0, 3'd7);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset in the middle of traffic with both requests high.
    apply(mk("mid_reset", 1, 1, 1, 8'h33, 1, 0, 3'd0));
    apply(mk("rd_after_reset", 0, 0, 1, 8'h00, 1, 0, 3'd0));
    // Single word: show-ahead presents it next cycle, registered mode after the pop.
    apply(mk("one_wr", 0, 1, 0, 8'h5A, 0, 0, 3'd1));
    apply(mk("one_rd", 0, 0, 1, 8'h00, 1, 0, 3'd0));
    chk("last_word_held_off", q_off, 32'h5A);
    apply(mk("idle", 0, 0, 0, 8'h00, 1, 0, 3'd0));
    chk("idle_hold_off", q_off, 32'h5A);

    wr_req = 1'b0;
    rd_req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
